// File: rtl/ch0re_div_seq_pkg.sv
// Shared types for the iterative RV64M divider controller.
// Optional build macro: CH0RE_DIV_WORD_EN (adds the 32-bit W-form ops).
package ch0re_div_seq_pkg;

  localparam int DIV_ITERS   = 64;
  localparam int DIV_W_ITERS = 32;

  // Divide/remainder flavour, signed and unsigned.
  typedef enum logic [1:0] {
    DIV_S = 2'd0,
    DIV_U = 2'd1,
    REM_S = 2'd2,
    REM_U = 2'd3
  } div_op_e;

  // Controller state, also exported on the debug port.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Operation select of the shared execute-stage ALU.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_LT   = 4'd8,
    ALU_LTU  = 4'd9
  } alu_op_e;

  // Sign-extend the low word of a 64-bit value.
  function automatic logic [63:0] sext32(input logic [63:0] x);
    return {{32{x[31]}}, x[31:0]};
  endfunction

endpackage

// File: rtl/ch0re_div_seq_if.sv
// Request/response handshake bundle for ch0re_div_seq.
// Optional build macro: CH0RE_DIV_WORD_EN (adds i_word).
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; the sender holds its payload stable while valid is high and
// ready is low, and ready never depends combinationally on the same-cycle
// valid of the other side.
interface ch0re_div_seq_if;
  import ch0re_div_seq_pkg::*;

  logic        i_valid;
  logic        o_ready;
  div_op_e     i_op;
  logic [63:0] i_s1;
  logic [63:0] i_s2;
`ifdef CH0RE_DIV_WORD_EN
  logic        i_word;
`endif
  logic        o_valid;
  logic        i_ready;
  logic [63:0] o_res;

  // Requester / result consumer side.
  modport master (
    output i_valid, i_op, i_s1, i_s2,
`ifdef CH0RE_DIV_WORD_EN
    output i_word,
`endif
    output i_ready,
    input  o_ready, o_valid, o_res
  );

  // Divider side.
  modport slave (
    input  i_valid, i_op, i_s1, i_s2,
`ifdef CH0RE_DIV_WORD_EN
    input  i_word,
`endif
    input  i_ready,
    output o_ready, o_valid, o_res
  );

endinterface

// File: rtl/ch0re_div_seq_sign.sv
// Combinational conditional two's-complement negate, used both for taking
// |x| of the operands and for restoring the result sign.
module ch0re_div_sign #(
  parameter int W = 64
) (
  input  logic [W-1:0] i_a,
  input  logic         i_neg,
  output logic [W-1:0] o_y
);

  assign o_y = i_neg ? (~i_a + W'(1)) : i_a;

endmodule

// File: rtl/ch0re_div_seq.sv
// Iterative restoring divider controller for DIV/DIVU/REM/REMU. It owns no
// subtractor: every iteration borrows the execute-stage ALU with ALU_LTU,
// using its compare flag and its difference output.
// Optional build macro: CH0RE_DIV_WORD_EN (adds DIVW/DIVUW/REMW/REMUW).
module ch0re_div_seq
  import ch0re_div_seq_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  ch0re_div_seq_if.slave    bus,
  output alu_op_e           o_alu_op,
  output logic [XLEN-1:0]   o_alu_s1,
  output logic [XLEN-1:0]   o_alu_s2,
  input  logic [XLEN-1:0]   i_alu_res,
  input  logic              i_alu_flag_lt,
  output div_state_e        o_dbg_state
);

  div_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, res_q;
  logic            is_rem_q, sign_q_q, sign_r_q;

  logic            signed_op, is_rem, accept, div_zero, ovf, special;
  logic [XLEN-1:0] s1_ext, s2_ext, s1_abs, s2_abs, min_val;
  logic [XLEN-1:0] spec_res, spec_res_w, quo_init;
  logic [CNT_W-1:0] cnt_init;
  logic [XLEN-1:0] shifted, quo_fix, rem_fix, fix_res, fix_res_w;
  logic            carry, take;
  logic            ready_c, valid_c;

  assign signed_op = (bus.i_op == DIV_S) || (bus.i_op == REM_S);
  assign is_rem    = (bus.i_op == REM_S) || (bus.i_op == REM_U);
  // Flush wins over a same-cycle request.
  assign accept    = bus.i_valid && (state_q == IDLE) && !i_flush;

`ifdef CH0RE_DIV_WORD_EN
  logic word_q;
  // W-form ops work on the low word, extended according to signedness.
  assign s1_ext   = bus.i_word ? (signed_op ? sext32(bus.i_s1) : {32'h0, bus.i_s1[31:0]})
                               : bus.i_s1;
  assign s2_ext   = bus.i_word ? (signed_op ? sext32(bus.i_s2) : {32'h0, bus.i_s2[31:0]})
                               : bus.i_s2;
  assign min_val  = bus.i_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
  assign quo_init = bus.i_word ? {s1_abs[31:0], 32'h0} : s1_abs;
  assign cnt_init = bus.i_word ? CNT_W'(DIV_W_ITERS) : CNT_W'(DIV_ITERS);
  assign spec_res_w = bus.i_word ? sext32(spec_res) : spec_res;
  assign fix_res_w  = word_q ? sext32(fix_res) : fix_res;
`else
  assign s1_ext     = bus.i_s1;
  assign s2_ext     = bus.i_s2;
  assign min_val    = 64'h8000_0000_0000_0000;
  assign quo_init   = s1_abs;
  assign cnt_init   = CNT_W'(DIV_ITERS);
  assign spec_res_w = spec_res;
  assign fix_res_w  = fix_res;
`endif

  ch0re_div_sign #(.W(XLEN)) u_abs_s1 (
    .i_a   (s1_ext),
    .i_neg (signed_op && s1_ext[XLEN-1]),
    .o_y   (s1_abs)
  );

  ch0re_div_sign #(.W(XLEN)) u_abs_s2 (
    .i_a   (s2_ext),
    .i_neg (signed_op && s2_ext[XLEN-1]),
    .o_y   (s2_abs)
  );

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  assign div_zero = (s2_ext == '0);
  assign ovf      = signed_op && (s1_ext == min_val) && (s2_ext == '1);
  assign special  = div_zero || ovf;
  assign spec_res = div_zero ? (is_rem ? s1_ext : '1)
                             : (is_rem ? '0 : s1_ext);

  // One shift-subtract step; a set carry means the shifted remainder already
  // exceeds any divisor, and the ALU's modulo-2^64 difference is exact.
  assign shifted = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
  assign carry   = rem_q[XLEN-1];
  assign take    = carry || !i_alu_flag_lt;

  ch0re_div_sign #(.W(XLEN)) u_fix_q (
    .i_a   (quo_q),
    .i_neg (sign_q_q),
    .o_y   (quo_fix)
  );

  ch0re_div_sign #(.W(XLEN)) u_fix_r (
    .i_a   (rem_q),
    .i_neg (sign_r_q),
    .o_y   (rem_fix)
  );

  assign fix_res = is_rem_q ? rem_fix : quo_fix;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = special ? DONE : ITER;
      ITER: if (cnt_q == CNT_W'(1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (bus.i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_flush) state_d = IDLE;
  end

  // Output decode: handshake flags and the borrowed ALU operands.
  always_comb begin
    ready_c  = 1'b0;
    valid_c  = 1'b0;
    o_alu_op = ALU_ADD;
    o_alu_s1 = '0;
    o_alu_s2 = '0;
    unique case (state_q)
      IDLE: ready_c = 1'b1;
      ITER: begin
        o_alu_op = ALU_LTU;
        o_alu_s1 = shifted;
        o_alu_s2 = dvs_q;
      end
      DONE: valid_c = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture, iteration and result formation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      res_q    <= '0;
      is_rem_q <= 1'b0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
`ifdef CH0RE_DIV_WORD_EN
      word_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          is_rem_q <= is_rem;
          dvs_q    <= s2_abs;
          sign_q_q <= (bus.i_op == DIV_S) && (s1_ext[XLEN-1] ^ s2_ext[XLEN-1]);
          sign_r_q <= (bus.i_op == REM_S) && s1_ext[XLEN-1];
`ifdef CH0RE_DIV_WORD_EN
          word_q   <= bus.i_word;
`endif
          if (special) begin
            res_q <= spec_res_w;
          end else begin
            rem_q <= '0;
            quo_q <= quo_init;
            cnt_q <= cnt_init;
          end
        end
        ITER: begin
          rem_q <= take ? i_alu_res : shifted;
          quo_q <= {quo_q[XLEN-2:0], take};
          cnt_q <= cnt_q - CNT_W'(1);
        end
        FIX: res_q <= fix_res_w;
        default: ;
      endcase
    end
  end

  assign bus.o_ready = ready_c;
  assign bus.o_valid = valid_c;
  assign bus.o_res   = res_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_ch0re_div_seq.sv
// Self-checking bench for ch0re_div_seq with a behavioural model of the
// shared ALU and a result scoreboard.
module tb_ch0re_div_seq;
  import ch0re_div_seq_pkg::*;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  ch0re_div_seq_if bus();

  alu_op_e     alu_op;
  logic [63:0] alu_s1, alu_s2, alu_res;
  logic        alu_lt;
  div_state_e  dbg_state;
  logic        word_sel = 1'b0;

  // Execute-stage ALU behaviour as seen by the divider.
  assign alu_res = (alu_op == ALU_LTU) ? (alu_s1 - alu_s2) : (alu_s1 + alu_s2);
  assign alu_lt  = (alu_s1 < alu_s2);

`ifdef CH0RE_DIV_WORD_EN
  assign bus.i_word = word_sel;
`endif

  ch0re_div_seq dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_flush       (flush),
    .bus           (bus),
    .o_alu_op      (alu_op),
    .o_alu_s1      (alu_s1),
    .o_alu_s2      (alu_s2),
    .i_alu_res     (alu_res),
    .i_alu_flag_lt (alu_lt),
    .o_dbg_state   (dbg_state)
  );

  // Scoreboard.
  logic [63:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Reference RV64M semantics for the random vectors.
  function automatic logic [63:0] ref_res(input div_op_e op, input logic [63:0] a, input logic [63:0] b);
    logic ov;
    ov = (a == MIN64) && (b == ONES);
    case (op)
      DIV_U:   return (b == 0) ? ONES : a / b;
      REM_U:   return (b == 0) ? a : a % b;
      DIV_S:   return (b == 0) ? ONES : ov ? MIN64 : 64'($signed(a) / $signed(b));
      default: return (b == 0) ? a : ov ? 64'h0 : 64'($signed(a) % $signed(b));
    endcase
  endfunction

  function automatic int ref_iters(input div_op_e op, input logic [63:0] a, input logic [63:0] b);
    logic sgn;
    sgn = (op == DIV_S) || (op == REM_S);
    if (b == 0) return 0;
    if (sgn && a == MIN64 && b == ONES) return 0;
    return DIV_ITERS;
  endfunction

  // Driver: issue one request, track latency/ALU use, optionally stall, retire.
  task automatic do_op(input div_op_e op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] e, input int iters, input int stall);
    int lat_exp, cycles, ltu, bad, sbad;
    logic [63:0] held, ev;
    lat_exp = (iters == 0) ? 1 : iters + 2;
    chk("ready_before", 64'(bus.o_ready), 64'd1);
    exp_q.push_back(e);
    bus.i_op    = op;
    bus.i_s1    = a;
    bus.i_s2    = b;
    bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    cycles = 1; ltu = 0; bad = 0;
    while (!bus.o_valid && cycles < 200) begin
      if (alu_op == ALU_LTU) ltu++;
      else if (alu_op != ALU_ADD || alu_s1 != 0 || alu_s2 != 0) bad++;
      @(posedge clk); #1;
      cycles++;
    end
    chk("latency", 64'(cycles), 64'(lat_exp));
    chk("ltu_cycles", 64'(ltu), 64'(iters));
    chk("alu_idle", 64'(bad), 64'd0);
    held = bus.o_res;
    sbad = 0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (!bus.o_valid || bus.o_res !== held || bus.o_ready) sbad++;
    end
    if (stall > 0) chk("stall_stable", 64'(sbad), 64'd0);
    ev = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    chk("result", bus.o_res, ev);
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
    chk("handoff_valid", 64'(bus.o_valid), 64'd0);
    chk("handoff_ready", 64'(bus.o_ready), 64'd1);
  endtask

  // Start a request that will be killed (no scoreboard entry).
  task automatic start_raw(input div_op_e op, input logic [63:0] a, input logic [63:0] b);
    bus.i_op    = op;
    bus.i_s1    = a;
    bus.i_s2    = b;
    bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask

  initial begin
    div_op_e     rop;
    logic [63:0] ra, rb;
    int          vcnt;

    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_op    = DIV_U;
    bus.i_s1    = '0;
    bus.i_s2    = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.o_ready), 64'd1);
    chk("rst_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_res", bus.o_res, 64'd0);
    chk("rst_alu_op", 64'(alu_op), 64'(ALU_ADD));
    chk("rst_alu_s1", alu_s1, 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors.
    do_op(DIV_U, 64'd100, 64'd7, 64'd14, 64, 0);
    do_op(REM_U, 64'd100, 64'd7, 64'd2, 64, 0);
    do_op(DIV_S, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64, 0);
    do_op(REM_S, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 64, 0);
    do_op(REM_S, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64, 0);
    do_op(DIV_U, 64'd5, 64'd0, ONES, 0, 0);
    do_op(REM_U, 64'd5, 64'd0, 64'd5, 0, 0);
    do_op(DIV_S, MIN64, ONES, MIN64, 0, 0);
    do_op(REM_S, MIN64, ONES, 64'd0, 0, 0);
    do_op(DIV_U, ONES, 64'h8000_0000_0000_0001, 64'd1, 64, 0);
    do_op(REM_U, ONES, 64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE, 64, 0);
    do_op(DIV_S, MIN64, 64'd1, MIN64, 64, 0);

    // Backpressure in DONE.
    do_op(DIV_U, 64'd1000, 64'd10, 64'd100, 64, 5);

    // Random vectors checked against the reference model.
    for (int n = 0; n < 8; n++) begin
      rop = div_op_e'($urandom_range(0, 3));
      ra  = {$urandom(), $urandom()};
      if ($urandom_range(0, 1) == 1) rb = 64'($urandom_range(1, 1000));
      else                           rb = {$urandom(), $urandom()};
      if (n == 7) rb = 64'd0;
      do_op(rop, ra, rb, ref_res(rop, ra, rb), ref_iters(rop, ra, rb), 0);
    end

    // Flush in the middle of iterating.
    start_raw(DIV_U, 64'd12345, 64'd17);
    repeat (29) begin @(posedge clk); #1; end
    chk("flush_pre_state", 64'(dbg_state), 64'(ITER));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_state", 64'(dbg_state), 64'(IDLE));
    chk("flush_ready", 64'(bus.o_ready), 64'd1);
    vcnt = 0;
    for (int i = 0; i < 80; i++) begin
      if (bus.o_valid) vcnt++;
      @(posedge clk); #1;
    end
    chk("flush_no_valid", 64'(vcnt), 64'd0);

    // Reset in the middle of iterating.
    start_raw(DIV_U, 64'd999, 64'd3);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_ready", 64'(bus.o_ready), 64'd1);
    chk("mid_rst_valid", 64'(bus.o_valid), 64'd0);
    chk("mid_rst_res", bus.o_res, 64'd0);
    chk("mid_rst_alu_op", 64'(alu_op), 64'(ALU_ADD));
    chk("mid_rst_alu_s2", alu_s2, 64'd0);
    do_op(DIV_U, 64'd9, 64'd3, 64'd3, 64, 0);

`ifdef CH0RE_DIV_WORD_EN
    word_sel = 1'b1;
    do_op(DIV_S, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, DIV_W_ITERS, 0);
    do_op(DIV_S, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0, 0);
    word_sel = 1'b0;
`endif

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
